// File: rtl/next_pc_unit.sv
// rtl/next_pc_unit.sv - PC register with next-PC selection, return-address stack and alignment fault
module next_pc_unit #(
    parameter int               WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter int               RAS_DEPTH = 4
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Stall,
    input  logic             Branch,
    input  logic             BranchNZ,
    input  logic             ALUZero,
    input  logic             Uncondbranch,
    input  logic             Link,
    input  logic             BranchReg,
    input  logic             Ret,
    input  logic [WIDTH-1:0] SignExtImm,
    input  logic [WIDTH-1:0] RegTarget,
    output logic [WIDTH-1:0] CurrentPC,
    output logic [WIDTH-1:0] NextPC,
    output logic [WIDTH-1:0] LinkAddr,
    output logic             RasEmpty,
    output logic             RasFull,
    output logic             RasMismatch,
    output logic             Fault
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] ras [RAS_DEPTH];
    logic [PW-1:0]    ptr;
    logic [CW-1:0]    count;
    logic [PW-1:0]    pop_ptr;
    logic [WIDTH-1:0] branch_target;
    logic             active;
    logic             is_reg;
    logic             misalign;
    logic             set_fault;
    logic             do_push;
    logic             do_ret;

    assign branch_target = CurrentPC + (SignExtImm << 2);
    assign LinkAddr      = CurrentPC + WIDTH'(4);
    assign RasEmpty      = (count == '0);
    assign RasFull       = (count == CW'(RAS_DEPTH));
    assign pop_ptr       = ptr - PW'(1);

    always_comb begin
        NextPC = LinkAddr;
        if (Uncondbranch)
            NextPC = branch_target;
        else if (BranchReg)
            NextPC = RegTarget;
        else if (Branch && (ALUZero ^ BranchNZ))
            NextPC = branch_target;
    end

    // Uncondbranch masks BranchReg entirely: no pop and no alignment check.
    assign active    = ~Stall & ~Fault;
    assign is_reg    = active & ~Uncondbranch & BranchReg;
    assign misalign  = |RegTarget[1:0];
    assign set_fault = is_reg & misalign;
    assign do_ret    = is_reg & ~misalign & Ret;
    assign do_push   = active & Uncondbranch & Link;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            CurrentPC   <= RESET_PC;
            ptr         <= '0;
            count       <= '0;
            RasMismatch <= 1'b0;
            Fault       <= 1'b0;
        end else begin
            RasMismatch <= 1'b0;
            if (set_fault)
                Fault <= 1'b1;
            else if (active)
                CurrentPC <= NextPC;
            if (do_push) begin
                ptr <= ptr + PW'(1);
                if (!RasFull)
                    count <= count + CW'(1);
            end
            if (do_ret) begin
                if (!RasEmpty) begin
                    ptr         <= pop_ptr;
                    count       <= count - CW'(1);
                    RasMismatch <= (ras[pop_ptr] != RegTarget);
                end else begin
                    RasMismatch <= 1'b1;
                end
            end
        end
    end

    // Entries are don't-care after reset, so the storage carries no reset.
    always_ff @(posedge CLK) begin
        if (!Reset && do_push)
            ras[ptr] <= LinkAddr;
    end

endmodule
